// File: rtl/wb_pipe_stage_pkg.sv
// Shared opcode/funct3 encodings, writeback FSM states and decode helpers
// used by the writeback stage and its load extractor.
package wb_pipe_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } wb_state_e;

  // SYSTEM with funct3 != 0 is a CSR access; funct3 == 0 is ECALL/EBREAK/xRET.
  function automatic logic wb_is_csr(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_SYSTEM) && (funct3 != 3'b000);
  endfunction

  function automatic logic wb_writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
    return !((opcode == OP_STORE) || (opcode == OP_BRANCH) ||
             ((opcode == OP_SYSTEM) && (funct3 == 3'b000)));
  endfunction

endpackage

// File: rtl/wb_pipe_stage_load_extract.sv
// Combinational load-data aligner: picks the byte/half/word lane out of the
// raw memory word and sign- or zero-extends it to XLEN.
module load_extract
  import wb_pipe_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANE_W = $clog2(XLEN/8)
) (
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  assign b = 8'(data >> {lane, 3'b000});
  assign h = 16'(data >> {lane[LANE_W-1:1], 4'b0000});

  generate
    if (XLEN == 64) begin : g_w64
      assign w = 32'(data >> {lane[LANE_W-1], 5'b00000});
    end else begin : g_w32
      assign w = data[31:0];
    end
  endgenerate

  always_comb begin
    result = data;
    case (funct3)
      F3_LB:  result = XLEN'($signed(b));
      F3_LBU: result = XLEN'(b);
      F3_LH:  result = XLEN'($signed(h));
      F3_LHU: result = XLEN'(h);
      F3_LW:  result = XLEN'($signed(w));
      // LWU only exists at XLEN=64; at XLEN=32 it falls through as raw data.
      F3_LWU: if (XLEN == 64) result = XLEN'(w);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Writeback stage: accepts one instruction from MEM, waits for load data when
// needed, and drives registered RF/CSR write ports plus the instret counter.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [6:0]       opcode,
  input  logic [RA_W-1:0]  rd,
  input  logic [XLEN-1:0]  c,
  input  logic [XLEN-1:0]  pc4,
  input  logic [XLEN-1:0]  z_,
  input  logic             flush,
  input  logic             load_rsp_valid,
  input  logic [XLEN-1:0]  load_rsp_data,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             csr_we,
  output logic [XLEN-1:0]  csr_wdata,
  output logic [CNT_W-1:0] instret
);

  localparam int LANE_W = $clog2(XLEN/8);

  wb_state_e         state;
  logic [2:0]        ld_f3;
  logic [RA_W-1:0]   ld_rd;
  logic [LANE_W-1:0] ld_lane;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   nl_wdata;
  logic              accept;

  assign in_ready = (state != WAIT_LOAD) && !flush;
  assign accept   = in_valid && in_ready;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .funct3 (ld_f3),
    .lane   (ld_lane),
    .data   (load_rsp_data),
    .result (ld_data)
  );

  always_comb begin
    nl_wdata = c;
    if ((opcode == OP_JAL) || (opcode == OP_JALR)) nl_wdata = pc4;
    else if (wb_is_csr(opcode, funct3))            nl_wdata = z_;
  end

  // Outputs are registered on entry into COMMIT so they are valid for exactly
  // the COMMIT cycle; write strobes drop on every other edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      csr_we    <= 1'b0;
      csr_wdata <= '0;
      instret   <= '0;
      ld_f3     <= '0;
      ld_rd     <= '0;
      ld_lane   <= '0;
    end else begin
      rf_we  <= 1'b0;
      csr_we <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          WAIT_LOAD: begin
            if (load_rsp_valid) begin
              state    <= COMMIT;
              rf_we    <= (ld_rd != '0);
              rf_waddr <= ld_rd;
              rf_wdata <= ld_data;
              instret  <= instret + 1'b1;
            end
          end
          default: begin
            if (!accept) begin
              state <= IDLE;
            end else if (opcode == OP_LOAD) begin
              state   <= WAIT_LOAD;
              ld_f3   <= funct3;
              ld_rd   <= rd;
              ld_lane <= c[LANE_W-1:0];
            end else begin
              state     <= COMMIT;
              rf_we     <= (rd != '0) && wb_writes_rd(opcode, funct3);
              rf_waddr  <= rd;
              rf_wdata  <= nl_wdata;
              csr_we    <= wb_is_csr(opcode, funct3);
              csr_wdata <= c;
              instret   <= instret + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: XLEN=32 instance for the main datapath and
// flush/reset cases, XLEN=64/CNT_W=4 instance for word lanes and counter wrap.
module tb_wb_pipe_stage;
  import wb_pipe_stage_pkg::*;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // XLEN=32 instance
  logic        a_rst_n = 1'b0, a_valid = 1'b0, a_ready, a_flush = 1'b0;
  logic [2:0]  a_f3 = '0;
  logic [6:0]  a_op = '0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_c = '0, a_pc4 = '0, a_z = '0;
  logic        a_rsp_v = 1'b0;
  logic [31:0] a_rsp_d = '0;
  logic        a_rf_we, a_csr_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata, a_csr_wdata;
  logic [63:0] a_instret;

  // XLEN=64, CNT_W=4 instance
  logic        b_rst_n = 1'b0, b_valid = 1'b0, b_ready, b_flush = 1'b0;
  logic [2:0]  b_f3 = '0;
  logic [6:0]  b_op = '0;
  logic [4:0]  b_rd = '0;
  logic [63:0] b_c = '0, b_pc4 = '0, b_z = '0;
  logic        b_rsp_v = 1'b0;
  logic [63:0] b_rsp_d = '0;
  logic        b_rf_we, b_csr_we;
  logic [4:0]  b_waddr;
  logic [63:0] b_wdata, b_csr_wdata;
  logic [3:0]  b_instret;

  wb_pipe_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .funct3(a_f3), .opcode(a_op), .rd(a_rd), .c(a_c), .pc4(a_pc4), .z_(a_z),
    .flush(a_flush), .load_rsp_valid(a_rsp_v), .load_rsp_data(a_rsp_d),
    .rf_we(a_rf_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata),
    .csr_we(a_csr_we), .csr_wdata(a_csr_wdata), .instret(a_instret)
  );

  wb_pipe_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .funct3(b_f3), .opcode(b_op), .rd(b_rd), .c(b_c), .pc4(b_pc4), .z_(b_z),
    .flush(b_flush), .load_rsp_valid(b_rsp_v), .load_rsp_data(b_rsp_d),
    .rf_we(b_rf_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
    .csr_we(b_csr_we), .csr_wdata(b_csr_wdata), .instret(b_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] cv, input logic [31:0] p, input logic [31:0] z);
    a_valid = 1'b1; a_op = op; a_f3 = f3; a_rd = r; a_c = cv; a_pc4 = p; a_z = z;
  endtask

  // Accept a load, idle one cycle, then return the response.
  task automatic a_load(input logic [2:0] f3, input logic [4:0] r, input logic [31:0] cv,
                        input logic [31:0] d);
    a_issue(OP_LOAD, f3, r, cv, 32'h0, 32'h0);
    tick();
    a_valid = 1'b0;
    tick();
    a_rsp_v = 1'b1; a_rsp_d = d;
    tick();
    a_rsp_v = 1'b0;
  endtask

  task automatic b_load(input logic [2:0] f3, input logic [63:0] cv, input logic [63:0] d);
    b_valid = 1'b1; b_op = OP_LOAD; b_f3 = f3; b_rd = 5'd10; b_c = cv;
    tick();
    b_valid = 1'b0;
    b_rsp_v = 1'b1; b_rsp_d = d;
    tick();
    b_rsp_v = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_rf_we",    {63'd0, a_rf_we},  64'd0);
    chk("rst_csr_we",   {63'd0, a_csr_we}, 64'd0);
    chk("rst_waddr",    {59'd0, a_waddr},  64'd0);
    chk("rst_wdata",    {32'd0, a_wdata},  64'd0);
    chk("rst_csr_wdata",{32'd0, a_csr_wdata}, 64'd0);
    chk("rst_instret",  a_instret,         64'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {63'd0, a_ready}, 64'd1);

    // ADD rd=3, c=5
    a_issue(OP_ADD, 3'b000, 5'd3, 32'h5, 32'h0, 32'h0);
    tick(); a_valid = 1'b0;
    chk("add_we",      {63'd0, a_rf_we},  64'd1);
    chk("add_waddr",   {59'd0, a_waddr},  64'd3);
    chk("add_wdata",   {32'd0, a_wdata},  64'd5);
    chk("add_csr_we",  {63'd0, a_csr_we}, 64'd0);
    chk("add_instret", a_instret,         64'd1);

    // LB with the WAIT_LOAD state observed in between
    a_issue(OP_LOAD, F3_LB, 5'd5, 32'h1003, 32'h0, 32'h0);
    tick(); a_valid = 1'b0;
    chk("wait_ready", {63'd0, a_ready}, 64'd0);
    chk("wait_we",    {63'd0, a_rf_we}, 64'd0);
    tick();
    a_rsp_v = 1'b1; a_rsp_d = 32'h80AA_BBCC;
    tick(); a_rsp_v = 1'b0;
    chk("lb_we",      {63'd0, a_rf_we}, 64'd1);
    chk("lb_waddr",   {59'd0, a_waddr}, 64'd5);
    chk("lb_wdata",   {32'd0, a_wdata}, 64'hFFFF_FF80);
    chk("lb_instret", a_instret,        64'd2);

    a_load(F3_LBU, 5'd5, 32'h1003, 32'h80AA_BBCC);
    chk("lbu_wdata",   {32'd0, a_wdata}, 64'h0000_0080);
    chk("lbu_instret", a_instret,        64'd3);

    // JAL rd=0
    a_issue(OP_JAL, 3'b000, 5'd0, 32'h0, 32'h104, 32'h0);
    tick(); a_valid = 1'b0;
    chk("jal_rd0_we",  {63'd0, a_rf_we}, 64'd0);
    chk("jal_instret", a_instret,        64'd4);

    // CSRRW
    a_issue(OP_SYSTEM, 3'b001, 5'd7, 32'h22, 32'h0, 32'h11);
    tick(); a_valid = 1'b0;
    chk("csr_rf_we",   {63'd0, a_rf_we},  64'd1);
    chk("csr_wdata_rf",{32'd0, a_wdata},  64'h11);
    chk("csr_we",      {63'd0, a_csr_we}, 64'd1);
    chk("csr_wdata",   {32'd0, a_csr_wdata}, 64'h22);

    // Back-to-back ADD then STORE, then idle
    a_issue(OP_ADD, 3'b000, 5'd1, 32'hA, 32'h0, 32'h0);
    tick();
    chk("b2b_add_wdata", {32'd0, a_wdata}, 64'hA);
    chk("b2b_add_inst",  a_instret,        64'd6);
    a_issue(OP_STORE, F3_LW, 5'd8, 32'h99, 32'h0, 32'h0);
    tick(); a_valid = 1'b0;
    chk("store_we",   {63'd0, a_rf_we}, 64'd0);
    chk("store_inst", a_instret,        64'd7);
    tick();
    chk("idle_we",    {63'd0, a_rf_we}, 64'd0);
    chk("idle_inst",  a_instret,        64'd7);

    // Flush coincident with the load response kills the load
    a_issue(OP_LOAD, F3_LH, 5'd9, 32'h2, 32'h0, 32'h0);
    tick(); a_valid = 1'b0;
    a_flush = 1'b1; a_rsp_v = 1'b1; a_rsp_d = 32'h1234_5678;
    #1;
    chk("flush_ready", {63'd0, a_ready}, 64'd0);
    tick(); a_flush = 1'b0; a_rsp_v = 1'b0;
    chk("flush_ld_we",   {63'd0, a_rf_we}, 64'd0);
    chk("flush_ld_inst", a_instret,        64'd7);
    a_issue(OP_ADD, 3'b000, 5'd4, 32'h33, 32'h0, 32'h0);
    tick(); a_valid = 1'b0;
    chk("post_flush_we",    {63'd0, a_rf_we}, 64'd1);
    chk("post_flush_wdata", {32'd0, a_wdata}, 64'h33);
    chk("post_flush_inst",  a_instret,        64'd8);

    // Flush during COMMIT: that commit stands, the new accept is suppressed
    a_issue(OP_ADD, 3'b000, 5'd2, 32'h44, 32'h0, 32'h0);
    tick();
    chk("fc_commit_we",   {63'd0, a_rf_we}, 64'd1);
    chk("fc_commit_inst", a_instret,        64'd9);
    a_flush = 1'b1;
    a_issue(OP_ADD, 3'b000, 5'd6, 32'h55, 32'h0, 32'h0);
    tick(); a_flush = 1'b0; a_valid = 1'b0;
    chk("fc_supp_we",   {63'd0, a_rf_we}, 64'd0);
    chk("fc_supp_inst", a_instret,        64'd9);

    // Halfword / word / raw loads at XLEN=32
    a_load(F3_LH, 5'd11, 32'h2, 32'h8001_1234);
    chk("lh_wdata",  {32'd0, a_wdata}, 64'hFFFF_8001);
    a_load(F3_LHU, 5'd11, 32'h3, 32'h8001_1234);
    chk("lhu_wdata", {32'd0, a_wdata}, 64'h0000_8001);
    a_load(F3_LW, 5'd11, 32'h0, 32'h8001_1234);
    chk("lw_wdata",  {32'd0, a_wdata}, 64'h8001_1234);
    a_load(3'b111, 5'd11, 32'h1, 32'hCAFE_F00D);
    chk("raw111_wdata", {32'd0, a_wdata}, 64'hCAFE_F00D);
    chk("raw111_inst",  a_instret,        64'd13);

    // Response in IDLE is ignored
    a_rsp_v = 1'b1; a_rsp_d = 32'h7;
    tick(); a_rsp_v = 1'b0;
    chk("idle_rsp_we",   {63'd0, a_rf_we}, 64'd0);
    chk("idle_rsp_inst", a_instret,        64'd13);

    // Reset abandons a pending load
    a_issue(OP_LOAD, F3_LW, 5'd12, 32'h0, 32'h0, 32'h0);
    tick(); a_valid = 1'b0;
    #2 a_rst_n = 1'b0;
    #1;
    chk("async_rst_inst",  a_instret,        64'd0);
    chk("async_rst_wdata", {32'd0, a_wdata}, 64'd0);
    a_rst_n = 1'b1;
    #1;
    chk("rst_ready", {63'd0, a_ready}, 64'd1);
    a_rsp_v = 1'b1; a_rsp_d = 32'h1;
    tick(); a_rsp_v = 1'b0;
    chk("rst_ld_we",   {63'd0, a_rf_we}, 64'd0);
    chk("rst_ld_inst", a_instret,        64'd0);

    // XLEN=64 word lanes
    b_load(F3_LWU, 64'h4, 64'h8000_0001_DEAD_BEEF);
    chk("lwu64_we",    {63'd0, b_rf_we}, 64'd1);
    chk("lwu64_wdata", b_wdata,          64'h0000_0000_8000_0001);
    b_load(F3_LW, 64'h4, 64'h8000_0001_DEAD_BEEF);
    chk("lw64_wdata",  b_wdata,          64'hFFFF_FFFF_8000_0001);
    b_load(F3_LW, 64'h0, 64'h8000_0001_DEAD_BEEF);
    chk("lw64_lo",     b_wdata,          64'hFFFF_FFFF_DEAD_BEEF);
    b_load(F3_LD, 64'h0, 64'h8000_0001_DEAD_BEEF);
    chk("ld64_wdata",  b_wdata,          64'h8000_0001_DEAD_BEEF);
    chk("b_inst4",     {60'd0, b_instret}, 64'd4);

    // 12 more back-to-back commits: 16 total wraps a 4-bit counter to 0
    b_valid = 1'b1; b_op = OP_ADD; b_f3 = 3'b000; b_rd = 5'd1; b_c = 64'h1;
    repeat (12) tick();
    b_valid = 1'b0;
    chk("b_wrap_inst", {60'd0, b_instret}, 64'd0);
    chk("b_wrap_we",   {63'd0, b_rf_we},   64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
